// File: rtl/frame_sender.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : frame_sender                                                  |
// | Description : Reads FRAME_LEN 10-bit samples from a ring buffer and sends   |
// |               them byte-by-byte to a UART as A5, CHANNEL_ID, {hi,lo}...     |
// |               Optional XOR checksum byte via FRAME_SENDER_CHECKSUM_EN.      |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module frame_sender #(
    parameter int unsigned FRAME_LEN  = 64,
    parameter int unsigned RD_LAT     = 2,
    parameter logic [7:0]  CHANNEL_ID = 8'h01
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        Start,
    input  logic [31:0] Sample_in,
    output logic        Send_Frame,
    input  logic        Tx_Ready,
    output logic        TX_en,
    output logic [7:0]  Word_To_Send,
    output logic        Busy,
    output logic        Done
);

    localparam logic [7:0] c_SYNC_BYTE = 8'hA5;
    localparam logic [9:0] c_LAST_IDX  = 10'(FRAME_LEN - 1);
    localparam logic [2:0] c_RD_LAST   = 3'(RD_LAT - 1);
    localparam logic [7:0] c_WD_LAST   = 8'd254;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_WAITRD = 4'd2,
        ST_LOAD   = 4'd3,
        ST_STROBE = 4'd4,
        ST_WAITLO = 4'd5,
        ST_WAITHI = 4'd6,
        ST_NEXT   = 4'd7,
        ST_FIN    = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        B_SYNC = 3'd0,
        B_CHAN = 3'd1,
        B_SHI  = 3'd2,
        B_SLO  = 3'd3,
        B_CSUM = 3'd4
    } byte_sel_t;

    state_t     r_state, w_state_nxt;
    byte_sel_t  r_sel, w_sel_nxt;
    logic [9:0] r_smp_idx, w_smp_idx_nxt;
    logic [2:0] r_rd_cnt, w_rd_cnt_nxt;
    logic [7:0] r_wd_cnt, w_wd_cnt_nxt;
    logic [7:0] r_sample_lo, w_sample_lo_nxt;
    logic [7:0] r_word, w_word_nxt;
    logic       r_send, r_txen, r_busy, r_done;
    logic       w_accept;
    logic       w_frame_start;
    logic       w_unused_bits;

    assign w_unused_bits = ^Sample_in[31:10];

`ifdef FRAME_SENDER_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_csum <= 8'h00;
        end else if (w_frame_start) begin
            r_csum <= 8'h00;
        end else if (w_accept) begin
            r_csum <= r_csum ^ r_word;
        end
    end
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_smp_idx_nxt   = r_smp_idx;
        w_rd_cnt_nxt    = r_rd_cnt;
        w_wd_cnt_nxt    = r_wd_cnt;
        w_sample_lo_nxt = r_sample_lo;
        w_word_nxt      = r_word;
        w_accept        = 1'b0;
        w_frame_start   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_frame_start = 1'b1;
                    w_sel_nxt     = B_SYNC;
                    w_word_nxt    = c_SYNC_BYTE;
                    w_smp_idx_nxt = 10'd0;
                    w_state_nxt   = ST_LOAD;
                end
            end
            ST_FETCH: begin
                w_rd_cnt_nxt = 3'd0;
                w_state_nxt  = ST_WAITRD;
            end
            ST_WAITRD: begin
                if (r_rd_cnt == c_RD_LAST) begin
                    w_sample_lo_nxt = Sample_in[7:0];
                    w_word_nxt      = {6'b0, Sample_in[9:8]};
                    w_sel_nxt       = B_SHI;
                    w_state_nxt     = ST_LOAD;
                end else begin
                    w_rd_cnt_nxt = r_rd_cnt + 3'd1;
                end
            end
            ST_LOAD: begin
                if (Tx_Ready) begin
                    w_state_nxt = ST_STROBE;
                end
            end
            ST_STROBE: begin
                w_wd_cnt_nxt = 8'd0;
                w_state_nxt  = ST_WAITLO;
            end
            ST_WAITLO: begin
                // A UART that never drops Tx_Ready missed the strobe; move on anyway.
                if (!Tx_Ready) begin
                    w_state_nxt = ST_WAITHI;
                end else if (r_wd_cnt == c_WD_LAST) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_NEXT;
                end else begin
                    w_wd_cnt_nxt = r_wd_cnt + 8'd1;
                end
            end
            ST_WAITHI: begin
                if (Tx_Ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                case (r_sel)
                    B_SYNC: begin
                        w_sel_nxt   = B_CHAN;
                        w_word_nxt  = CHANNEL_ID;
                        w_state_nxt = ST_LOAD;
                    end
                    B_CHAN: begin
                        w_state_nxt = ST_FETCH;
                    end
                    B_SHI: begin
                        w_sel_nxt   = B_SLO;
                        w_word_nxt  = r_sample_lo;
                        w_state_nxt = ST_LOAD;
                    end
                    B_SLO: begin
                        if (r_smp_idx == c_LAST_IDX) begin
`ifdef FRAME_SENDER_CHECKSUM_EN
                            w_sel_nxt   = B_CSUM;
                            w_word_nxt  = r_csum;
                            w_state_nxt = ST_LOAD;
`else
                            w_state_nxt = ST_FIN;
`endif
                        end else begin
                            w_smp_idx_nxt = r_smp_idx + 10'd1;
                            w_state_nxt   = ST_FETCH;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_FIN;
                    end
                endcase
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Strobe outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state     <= ST_IDLE;
            r_sel       <= B_SYNC;
            r_smp_idx   <= 10'd0;
            r_rd_cnt    <= 3'd0;
            r_wd_cnt    <= 8'd0;
            r_sample_lo <= 8'h00;
            r_word      <= 8'h00;
            r_send      <= 1'b0;
            r_txen      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_smp_idx   <= w_smp_idx_nxt;
            r_rd_cnt    <= w_rd_cnt_nxt;
            r_wd_cnt    <= w_wd_cnt_nxt;
            r_sample_lo <= w_sample_lo_nxt;
            r_word      <= w_word_nxt;
            r_send      <= (w_state_nxt == ST_FETCH);
            r_txen      <= (w_state_nxt == ST_STROBE);
            r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_FIN);
            r_done      <= (w_state_nxt == ST_FIN);
        end
    end

    assign Send_Frame   = r_send;
    assign TX_en        = r_txen;
    assign Word_To_Send = r_word;
    assign Busy         = r_busy;
    assign Done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_frame_sender.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_frame_sender                                               |
// | Description : Directed bench for frame_sender with UART and ring-buffer     |
// |               models; honours FRAME_SENDER_CHECKSUM_EN.                     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_frame_sender;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [31:0] sample_in = 32'h0;
    logic        tx_ready;
    logic        sf_a, txen_a, busy_a, done_a;
    logic        sf_b, txen_b, busy_b, done_b;
    logic [7:0]  word_a, word_b;

    always #5 clk = ~clk;

    frame_sender #(.FRAME_LEN(2), .RD_LAT(2), .CHANNEL_ID(8'h01)) u_dut_a (
        .clk(clk), .reset_b(reset_b), .Start(start_a), .Sample_in(sample_in),
        .Send_Frame(sf_a), .Tx_Ready(tx_ready), .TX_en(txen_a),
        .Word_To_Send(word_a), .Busy(busy_a), .Done(done_a)
    );

    frame_sender #(.FRAME_LEN(1), .RD_LAT(3), .CHANNEL_ID(8'h01)) u_dut_b (
        .clk(clk), .reset_b(reset_b), .Start(start_b), .Sample_in(sample_in),
        .Send_Frame(sf_b), .Tx_Ready(tx_ready), .TX_en(txen_b),
        .Word_To_Send(word_b), .Busy(busy_b), .Done(done_b)
    );

    logic       sel_b = 1'b0;
    logic       act_sf, act_txen, act_done, act_busy;
    logic [7:0] act_word;
    assign act_sf   = sel_b ? sf_b   : sf_a;
    assign act_txen = sel_b ? txen_b : txen_a;
    assign act_done = sel_b ? done_b : done_a;
    assign act_busy = sel_b ? busy_b : busy_a;
    assign act_word = sel_b ? word_b : word_a;

    logic uart_rdy = 1'b1, hold_low = 1'b0, ignore_one = 1'b0;
    assign tx_ready = uart_rdy & ~hold_low;

    int         total = 0, bad = 0;
    int         cyc = 0, sf_cnt = 0, done_cnt = 0, uart_cnt = 0;
    int         lat_cnt = 0, sidx = 0, rdlat = 2;
    bit         pend = 1'b0;
    logic [9:0] samp [0:3];
    logic [7:0] rx_q [$];
    int         tx_t [$];
    logic [7:0] exp_b [0:7];
    int         exp_n = 0;

    // UART and ring-buffer models; Sample_in carries garbage except on the exact latency cycle.
    always @(negedge clk) begin
        cyc++;
        if (act_sf) sf_cnt++;
        if (act_done) done_cnt++;
        if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) uart_rdy = 1'b1;
        end
        if (act_txen) begin
            rx_q.push_back(act_word);
            tx_t.push_back(cyc);
            if (ignore_one) ignore_one = 1'b0;
            else begin
                uart_rdy = 1'b0;
                uart_cnt = 3;
            end
        end
        if (pend) lat_cnt++;
        if (act_sf) begin
            pend    = 1'b1;
            lat_cnt = 0;
        end
        if (pend && lat_cnt == rdlat) begin
            sample_in = {22'h3A5A5A, samp[sidx]};
            pend      = 1'b0;
            sidx++;
        end else begin
            sample_in = {22'h3A5A5A, 10'h0F0};
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start(input bit which_b);
        if (which_b) start_b = 1'b1;
        else start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic clear_scn();
        rx_q.delete();
        tx_t.delete();
        sf_cnt   = 0;
        done_cnt = 0;
        sidx     = 0;
        pend     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int k = 0;
        while (done_cnt == 0 && k < max) begin
            step(1);
            k++;
        end
        check_val({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        step(3);
    endtask

    task automatic add_csum();
`ifdef FRAME_SENDER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        for (int i = 0; i < exp_n; i++) x ^= exp_b[i];
        exp_b[exp_n] = x;
        exp_n++;
`endif
    endtask

    task automatic check_pkt(input string tag);
        logic [31:0] got;
        check_val({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            got = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF;
            check_val($sformatf("%s_byte%0d", tag, i), got, 32'(exp_b[i]));
        end
    endtask

    initial begin
        int bad_cyc;
        int k;
        step(3);
        check_val("rst_send_frame", 32'(sf_a), 32'd0);
        check_val("rst_tx_en", 32'(txen_a), 32'd0);
        check_val("rst_word", 32'(word_a), 32'd0);
        check_val("rst_busy", 32'(busy_a), 32'd0);
        check_val("rst_done", 32'(done_a), 32'd0);
        reset_b = 1'b1;
        step(2);

        // Scenario 1: two samples; XOR of A5,01,03,FF,00,01 is 59
        samp[0] = 10'h3FF;
        samp[1] = 10'h001;
        exp_b = '{8'hA5, 8'h01, 8'h03, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00};
        exp_n = 6;
        add_csum();
        clear_scn();
        pulse_start(1'b0);
        check_val("s1_busy_after_start", 32'(busy_a), 32'd1);
        wait_done("s1", 500);
        check_pkt("s1");
        check_val("s1_done_cnt", 32'(done_cnt), 32'd1);
        check_val("s1_send_frame_cnt", 32'(sf_cnt), 32'd2);
        check_val("s1_busy_end", 32'(busy_a), 32'd0);

        // Scenario 2: extra Starts mid-frame are ignored
        clear_scn();
        pulse_start(1'b0);
        step(4);
        pulse_start(1'b0);
        check_val("s2_busy_mid", 32'(busy_a), 32'd1);
        step(14);
        pulse_start(1'b0);
        wait_done("s2", 500);
        step(40);
        check_pkt("s2");
        check_val("s2_done_cnt", 32'(done_cnt), 32'd1);
        check_val("s2_send_frame_cnt", 32'(sf_cnt), 32'd2);

        // Scenario 3: reset while third byte waits for Tx_Ready to return
        clear_scn();
        pulse_start(1'b0);
        k = 0;
        while (tx_t.size() < 3 && k < 200) begin
            step(1);
            k++;
        end
        check_val("s3_third_strobe_seen", 32'(tx_t.size() >= 3), 32'd1);
        step(1);
        reset_b = 1'b0;
        #1;
        check_val("s3_rst_send_frame", 32'(sf_a), 32'd0);
        check_val("s3_rst_tx_en", 32'(txen_a), 32'd0);
        check_val("s3_rst_word", 32'(word_a), 32'd0);
        check_val("s3_rst_busy", 32'(busy_a), 32'd0);
        check_val("s3_rst_done", 32'(done_a), 32'd0);
        step(2);
        reset_b = 1'b1;
        step(10);
        check_val("s3_no_done", 32'(done_cnt), 32'd0);
        clear_scn();
        pulse_start(1'b0);
        wait_done("s3b", 500);
        check_pkt("s3b");

        // Scenario 4: UART busy before Start
        clear_scn();
        hold_low = 1'b1;
        step(100);
        pulse_start(1'b0);
        bad_cyc = 0;
        repeat (30) begin
            if (txen_a !== 1'b0 || word_a !== 8'hA5) bad_cyc++;
            step(1);
        end
        check_val("s4_hold_bad_cycles", 32'(bad_cyc), 32'd0);
        hold_low = 1'b0;
        wait_done("s4", 500);
        check_pkt("s4");
        check_val("s4_strobe_cnt", 32'(tx_t.size()), 32'(exp_n));

        // Scenario 5: first strobe lost, watchdog moves on after 255 cycles
        clear_scn();
        ignore_one = 1'b1;
        pulse_start(1'b0);
        wait_done("s5", 1000);
        check_pkt("s5");
        check_val("s5_gap", (tx_t.size() >= 2) ? 32'(tx_t[1] - tx_t[0]) : 32'hFFFF_FFFF, 32'd258);
        check_val("s5_done_cnt", 32'(done_cnt), 32'd1);

        // Scenario 6: single sample, read latency 3; XOR of A5,01,01,55 is F0
        sel_b = 1'b1;
        rdlat = 3;
        step(2);
        samp[0] = 10'h155;
        exp_b = '{8'hA5, 8'h01, 8'h01, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_n = 4;
        add_csum();
        clear_scn();
        pulse_start(1'b1);
        wait_done("s6", 500);
        check_pkt("s6");
        check_val("s6_send_frame_cnt", 32'(sf_cnt), 32'd1);
        check_val("s6_done_cnt", 32'(done_cnt), 32'd1);
        check_val("s6_busy_end", 32'(act_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
